dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store port.
- Accepts one load or store request per transaction over a valid/ready request channel.
- Performs RV32I byte/half/word lane handling keyed by funct3, after a configurable access latency.
- Returns read data plus an error flag over a valid/ready response channel.
- Replaces the zero-latency data memory so the core can later be stalled on memory.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/lsu_lane.sv | 76 +++++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder and its load/store lane helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/lsu_lane.sv
// RV32I byte/half/word lane steering: store byte enables and data replication,
// load extraction and extension, plus alignment / funct3 legality.
module lsu_lane
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_raw_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      shifted  = rdata_raw_i >> {addr_lo_i, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
   end

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'h0;
      rdata_o = 32'h0;
      err_o   = 1'b0;
      if (we_i) begin
         case (funct3_i)
            F3_B: begin
               be_o    = 4'b0001 << addr_lo_i;
               wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
               err_o   = addr_lo_i[0];
               be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{wdata_i[15:0]}};
            end
            F3_W: begin
               err_o   = (addr_lo_i != 2'b00);
               be_o    = 4'b1111;
               wdata_o = wdata_i;
            end
            default: err_o = 1'b1;
         endcase
      end else begin
         case (funct3_i)
            F3_B:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: rdata_o = {24'h0, byte_sel};
            F3_H: begin
               err_o   = addr_lo_i[0];
               rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
               err_o   = addr_lo_i[0];
               rdata_o = {16'h0, half_sel};
            end
            F3_W: begin
               err_o   = (addr_lo_i != 2'b00);
               rdata_o = rdata_raw_i;
            end
            default: err_o = 1'b1;
         endcase
      end
      // A faulting access must neither write nor return data.
      if (err_o) begin
         be_o    = 4'b0000;
         rdata_o = 32'h0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port: valid/ready request and response
// channels around a word array, with a fixed access latency before commit.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CntInit = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    f3_q, f3_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   mem [DEPTH];

   logic          commit;
   logic          cur_we;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [2:0]    cur_f3;
   logic [AW-1:0] cur_idx;
   logic          in_range;
   logic [31:0]   raw_word;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_rdata;
   logic          lane_err;
   logic          acc_err;
   logic          mem_we;

   // With zero latency the commit happens on the accept edge, so use the live request.
   always_comb begin
      if (state_q == S_IDLE) begin
         cur_we    = req_we;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_f3    = req_funct3;
      end else begin
         cur_we    = we_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_f3    = f3_q;
      end
      cur_idx  = cur_addr[AW+1:2];
      in_range = ({2'b00, cur_addr[31:2]} < DEPTH);
      raw_word = in_range ? mem[cur_idx] : 32'h0;
   end

   lsu_lane u_lane (
      .funct3_i    (cur_f3),
      .addr_lo_i   (cur_addr[1:0]),
      .we_i        (cur_we),
      .wdata_i     (cur_wdata),
      .rdata_raw_i (raw_word),
      .be_o        (lane_be),
      .wdata_o     (lane_wdata),
      .rdata_o     (lane_rdata),
      .err_o       (lane_err)
   );

   assign acc_err = lane_err | ~in_range;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      f3_d        = f3_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      commit      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               f3_d    = req_funct3;
               if (LATENCY == 0) begin
                  commit  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = CntInit;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               commit  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (commit) begin
         rsp_rdata_d = acc_err ? 32'h0 : lane_rdata;
         rsp_err_d   = acc_err;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         f3_q        <= 3'b000;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         f3_q        <= f3_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign mem_we = commit & cur_we & ~acc_err & reset_n;

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_be[b]) mem[cur_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
         end
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for lane handling and errors,
// plus hand sequences for backpressure and mid-transaction reset.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned DEPTH   = 1024;
   localparam int unsigned LATENCY = 2;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total;
   int bad;

   dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [31:0] rd, input logic er);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
      v.exp_rdata = rd; v.exp_err = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the DUT back in IDLE.
   task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic er,
                      output int lat);
      int n;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clock); n++; end
      @(negedge clock);
      // Scramble the request after accept; it must not matter.
      req_valid = 1'b0; req_we = ~we; req_addr = a ^ 32'h4; req_wdata = ~wd; req_funct3 = 3'b111;
      lat = 1;
      while (!rsp_valid && lat < 50) begin @(negedge clock); lat++; end
      rd = rsp_rdata;
      er = rsp_err;
      @(negedge clock);
   endtask

   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clock); n++; end
      chk({name, " rsp timeout"}, 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] held;

      total = 0; bad = 0;
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_wdata = 32'h0; req_funct3 = 3'b000; rsp_ready = 1'b1;

      repeat (3) @(negedge clock);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'h0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("reset req_ready", 32'(req_ready), 32'd1);

      vecs.push_back(mk(1, 32'h0000_0000, 32'h1111_1111, F3_W,  32'h0000_0000, 0));
      vecs.push_back(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, F3_W,  32'h0000_0000, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_W,  32'hDEAD_BEEF, 0));
      vecs.push_back(mk(0, 32'h0000_0013, 32'h0,         F3_B,  32'hFFFF_FFDE, 0));
      vecs.push_back(mk(0, 32'h0000_0013, 32'h0,         F3_BU, 32'h0000_00DE, 0));
      vecs.push_back(mk(0, 32'h0000_0012, 32'h0,         F3_H,  32'hFFFF_DEAD, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_HU, 32'h0000_BEEF, 0));
      vecs.push_back(mk(1, 32'h0000_0011, 32'h0000_0055, F3_B,  32'h0000_0000, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_W,  32'hDEAD_55EF, 0));
      vecs.push_back(mk(1, 32'h0000_0012, 32'h0000_1234, F3_H,  32'h0000_0000, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_W,  32'h1234_55EF, 0));
      vecs.push_back(mk(0, 32'h0000_0011, 32'h0,         F3_W,  32'h0000_0000, 1));
      vecs.push_back(mk(1, 32'h0000_0013, 32'h0000_FFFF, F3_H,  32'h0000_0000, 1));
      vecs.push_back(mk(1, DEPTH * 4,     32'hCAFE_F00D, F3_W,  32'h0000_0000, 1));
      vecs.push_back(mk(0, 32'h0000_0000, 32'h0,         F3_W,  32'h1111_1111, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         3'b011, 32'h0000_0000, 1));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         3'b110, 32'h0000_0000, 1));
      vecs.push_back(mk(1, 32'h0000_0010, 32'h0,         3'b011, 32'h0000_0000, 1));
      vecs.push_back(mk(1, 32'h0000_0010, 32'h0,         F3_BU, 32'h0000_0000, 1));
      vecs.push_back(mk(0, 32'h0000_0011, 32'h0,         F3_H,  32'h0000_0000, 1));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_W,  32'h1234_55EF, 0));
      vecs.push_back(mk(1, 32'h0000_0010, 32'hAABB_CC77, F3_B,  32'h0000_0000, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_W,  32'h1234_5577, 0));
      vecs.push_back(mk(0, 32'h0000_0012, 32'h0,         F3_B,  32'h0000_0034, 0));
      vecs.push_back(mk(0, 32'h0000_0012, 32'h0,         F3_HU, 32'h0000_1234, 0));
      vecs.push_back(mk(0, 32'h0000_0010, 32'h0,         F3_H,  32'h0000_5577, 0));
      vecs.push_back(mk(1, 32'h0000_0FFC, 32'h8000_0001, F3_W,  32'h0000_0000, 0));
      vecs.push_back(mk(0, 32'h0000_0FFE, 32'h0,         F3_H,  32'hFFFF_8000, 0));
      vecs.push_back(mk(0, 32'h0000_0FFC, 32'h0,         F3_BU, 32'h0000_0001, 0));
      vecs.push_back(mk(0, 32'hFFFF_FFFC, 32'h0,         F3_W,  32'h0000_0000, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat);
         chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(LATENCY + 1));
      end

      // Backpressure: hold the response, offer a second request meanwhile.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W;
      chk("bp first ready", 32'(req_ready), 32'd1);
      @(negedge clock);
      req_valid = 1'b0;
      wait_rsp("bp");
      held = rsp_rdata;
      chk("bp rdata", held, 32'h1234_5577);
      req_valid = 1'b1; req_addr = 32'h13; req_funct3 = F3_B;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk($sformatf("bp hold%0d valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp hold%0d rdata", i), rsp_rdata, held);
         chk($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("bp released valid", 32'(rsp_valid), 32'd0);
      chk("bp released ready", 32'(req_ready), 32'd1);
      @(negedge clock);
      chk("bp second accepted", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      wait_rsp("bp2");
      chk("bp second rdata", rsp_rdata, 32'h0000_0012);
      @(negedge clock);

      // Reset while a store waits: it must never land.
      txn(1'b1, 32'h20, 32'h0BAD_F00D, F3_W, rd, er, lat);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5_A5A5;
      req_funct3 = F3_W;
      @(negedge clock);
      req_valid = 1'b0;
      chk("rw in wait", 32'(req_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("rw rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rw rsp_rdata", rsp_rdata, 32'h0);
      chk("rw rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rw ready after", 32'(req_ready), 32'd1);
      txn(1'b0, 32'h20, 32'h0, F3_W, rd, er, lat);
      chk("rw readback", rd, 32'h0BAD_F00D);

      // Reset while a committed store sits in RESP: it stays written.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h600D_CAFE;
      req_funct3 = F3_W;
      @(negedge clock);
      req_valid = 1'b0;
      wait_rsp("rr");
      chk("rr err", 32'(rsp_err), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("rr rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clock);
      txn(1'b0, 32'h24, 32'h0, F3_W, rd, er, lat);
      chk("rr readback", rd, 32'h600D_CAFE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
